axis_frame_guard: RTL and testbench

Downstream AXI4-Stream stage between the camera capture stream and the VDMA S2MM port. It enforces exact frame geometry: H_ACTIVE beats per line and V_ACTIVE lines per frame, with tuser on the first beat of each frame and tlast on the last beat of each line. It discards data until the first SOF. Malformed frames (short line, long line, early SOF) are completed with zero-padded beats, so the VDMA never loses frame lock. Each malformed frame is counted.

---
 rtl/cam_stream_pkg.sv | 28 ++
 rtl/axis_out_reg.sv | 61 ++++++
 rtl/axis_frame_guard.sv | 197 +++++++++++++++++++
 tb/tb_axis_frame_guard.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_stream_pkg.sv
// -----------------------------------------------------------------------------
// cam_stream_pkg
// Shared definitions for the camera AXI4-Stream stages: the frame-guard state
// enum, default stream geometry/width, and a helper that sizes position
// counters from a beat/line count.
// -----------------------------------------------------------------------------
package cam_stream_pkg;

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    PASS       = 2'd1,
    EXPECT_SOF = 2'd2,
    PAD        = 2'd3
  } guard_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_COL_W = cnt_w(DEF_H_ACTIVE);
  localparam int DEF_ROW_W = cnt_w(DEF_V_ACTIVE);

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// One-entry AXI4-Stream output register. A new beat is taken whenever the
// register is empty or the downstream consumer is taking the current beat, so
// o_load depends on i_ready but the registered outputs never do.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid             a beat is offered for loading this cycle
//   i_data/i_last/i_user  beat payload
//   i_ready             downstream tready
//   o_load              register can accept a beat this cycle
//   o_valid/o_data/o_last/o_user  registered stream outputs
// -----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_user,
  input  logic              i_ready,
  output logic              o_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_user
);

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_last_p1;
  logic              r_user_p1;

  assign o_load = !r_vld_p1 || i_ready;

  // ---- stage p1: output register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_user_p1 <= 1'b0;
    end else if (o_load) begin
      r_vld_p1 <= i_valid;
      if (i_valid) begin
        r_data_p1 <= i_data;
        r_last_p1 <= i_last;
        r_user_p1 <= i_user;
      end
    end
  end

  assign o_valid = r_vld_p1;
  assign o_data  = r_data_p1;
  assign o_last  = r_last_p1;
  assign o_user  = r_user_p1;

endmodule

// File: rtl/axis_frame_guard.sv
// -----------------------------------------------------------------------------
// axis_frame_guard
// Enforces exact frame geometry (H_ACTIVE beats per line, V_ACTIVE lines per
// frame) between the camera capture stream and the VDMA. Output tuser/tlast
// are regenerated from position counters. Malformed frames are completed with
// zero beats so the VDMA keeps frame lock; each malformed frame is counted.
//
// Ports:
//   axi_clk, axi_reset      clock, synchronous active-high reset
//   s_axis_*                input stream (tvalid/tready/tdata/tlast/tuser)
//   m_axis_*                output stream (tvalid/tready/tdata/tlast/tuser/tkeep)
//   frame_cnt               clean frames delivered (wraps)
//   err_cnt                 error events (saturates)
//   locked                  high while forwarding a frame (PASS)
// -----------------------------------------------------------------------------
module axis_frame_guard
  import cam_stream_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic                axi_clk,
  input  logic                axi_reset,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         err_cnt,
  output logic                locked
);

  localparam int COL_W = cnt_w(H_ACTIVE);
  localparam int ROW_W = cnt_w(V_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  guard_state_e      r_state, w_state_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt, w_col_adv;
  logic [ROW_W-1:0]  r_row, w_row_nxt, w_row_adv;
  logic              r_sof_held, w_sof_held_nxt;
  logic [15:0]       r_frame_cnt, r_err_cnt;
  logic              w_frame_inc, w_err_inc;
  logic              w_load, w_take, w_s_tready;
  logic              w_at_origin, w_col_end, w_row_end;
  logic              w_ld_vld, w_ld_last, w_ld_user;
  logic [DATA_W-1:0] w_ld_data;

  assign w_at_origin = (r_col == '0) && (r_row == '0);
  assign w_col_end   = (r_col == COL_LAST);
  assign w_row_end   = (r_row == ROW_LAST);
  assign w_col_adv   = w_col_end ? '0 : r_col + COL_W'(1);
  assign w_row_adv   = w_col_end ? r_row + ROW_W'(1) : r_row;

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_sof_held_nxt = r_sof_held;
    w_frame_inc    = 1'b0;
    w_err_inc      = 1'b0;
    w_s_tready     = 1'b0;
    w_take         = 1'b0;
    w_ld_vld       = 1'b0;
    w_ld_data      = s_axis_tdata;
    w_ld_last      = 1'b0;
    w_ld_user      = 1'b0;

    unique case (r_state)
      HUNT, EXPECT_SOF: begin
        w_s_tready = w_load;
        if (s_axis_tvalid && w_load) begin
          if (s_axis_tuser) begin
            w_take = 1'b1;
          end else if (r_state == EXPECT_SOF) begin
            w_err_inc   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
      end
      PASS: begin
        // An SOF away from (0,0) is refused and stays on the bus; PAD picks
        // it up again once the broken frame has been filled out. This also
        // takes priority over a short-line tlast on the same beat.
        w_s_tready = w_load && !(s_axis_tuser && !w_at_origin);
        w_take     = s_axis_tvalid && w_s_tready;
        if (s_axis_tvalid && s_axis_tuser && !w_at_origin) begin
          w_err_inc      = 1'b1;
          w_sof_held_nxt = 1'b1;
          w_state_nxt    = PAD;
        end
      end
      PAD: begin
        w_s_tready = !s_axis_tuser;
        if (s_axis_tvalid && s_axis_tuser) w_sof_held_nxt = 1'b1;
        if (w_load) begin
          w_ld_vld  = 1'b1;
          w_ld_data = '0;
          w_ld_last = w_col_end;
          w_col_nxt = w_col_adv;
          w_row_nxt = w_row_adv;
          if (w_col_end && w_row_end) begin
            w_col_nxt      = '0;
            w_row_nxt      = '0;
            w_sof_held_nxt = 1'b0;
            w_state_nxt    = (r_sof_held || (s_axis_tvalid && s_axis_tuser)) ? PASS : HUNT;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase

    // Accepted pixel at (r_col, r_row), whether it opens a frame or continues one.
    if (w_take) begin
      w_ld_vld    = 1'b1;
      w_ld_data   = s_axis_tdata;
      w_ld_user   = w_at_origin;
      w_ld_last   = w_col_end;
      w_state_nxt = PASS;
      w_col_nxt   = w_col_adv;
      w_row_nxt   = w_row_adv;
      if (s_axis_tlast && !w_col_end) begin
        w_err_inc   = 1'b1;
        w_state_nxt = PAD;
      end else if (w_col_end && !s_axis_tlast) begin
        w_err_inc = 1'b1;
        if (w_row_end) begin
          // Frame is already geometrically complete; nothing to pad.
          w_state_nxt = HUNT;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end else begin
          w_state_nxt = PAD;
        end
      end else if (w_col_end && w_row_end) begin
        w_frame_inc = 1'b1;
        w_state_nxt = EXPECT_SOF;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state     <= HUNT;
      r_col       <= '0;
      r_row       <= '0;
      r_sof_held  <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_sof_held <= w_sof_held_nxt;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err_inc)   r_err_cnt   <= sat_inc16(r_err_cnt);
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .i_clk   (axi_clk),
    .i_rst   (axi_reset),
    .i_valid (w_ld_vld),
    .i_data  (w_ld_data),
    .i_last  (w_ld_last),
    .i_user  (w_ld_user),
    .i_ready (m_axis_tready),
    .o_load  (w_load),
    .o_valid (m_axis_tvalid),
    .o_data  (m_axis_tdata),
    .o_last  (m_axis_tlast),
    .o_user  (m_axis_tuser)
  );

  assign s_axis_tready = w_s_tready && !axi_reset;
  assign m_axis_tkeep  = '1;
  assign frame_cnt     = r_frame_cnt;
  assign err_cnt       = r_err_cnt;
  assign locked        = (r_state == PASS);

endmodule

// File: tb/tb_axis_frame_guard.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_guard
// Scoreboard bench for axis_frame_guard with H_ACTIVE=8, V_ACTIVE=4. Stimulus
// pushes the expected output beats into a queue; an independent monitor pops
// and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_axis_frame_guard;

  localparam int DW = 32;
  localparam int H  = 8;
  localparam int V  = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tuser;
  logic [DW/8-1:0] m_tkeep;
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
  logic          locked;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready
  beat_t exp_q[$];

  always #5 clk = ~clk;

  axis_frame_guard #(
    .DATA_W   (DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .axi_clk       (clk),
    .axi_reset     (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tkeep  (m_tkeep),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .locked        (locked)
  );

  // Downstream ready pattern, changed just after each rising edge.
  initial begin : ready_gen
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = ($urandom_range(0, 3) != 0);
        1:       m_tready = 1'b1;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every output handshake against the scoreboard and
  // checks that a stalled beat holds steady.
  initial begin : monitor
    beat_t e;
    beat_t held;
    logic  stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!m_tvalid || m_tdata !== held.d || m_tlast !== held.l || m_tuser !== held.u) begin
            errors++;
            $display("FAIL stall_stable: got valid=%b data=%h last=%b user=%b, required valid=1 data=%h last=%b user=%b",
                     m_tvalid, m_tdata, m_tlast, m_tuser, held.d, held.l, held.u);
          end
        end
        stall  = m_tvalid && !m_tready;
        held.d = m_tdata;
        held.l = m_tlast;
        held.u = m_tuser;
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: got unexpected data=%h last=%b user=%b, required no beat",
                     m_tdata, m_tlast, m_tuser);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.d || m_tlast !== e.l || m_tuser !== e.u) begin
              errors++;
              $display("FAIL out_beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                       m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int r, input int c);
    return {8'hA5, f[7:0], r[7:0], c[7:0]};
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d;
    b.l = l;
    b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic u);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL handshake: tready low for data %h after %0d cycles, required accept", d, n);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // Clean beats of frame f, linear indices i0..i1 (index = row*H + col).
  task automatic clean_beats(input int f, input int i0, input int i1);
    logic [DW-1:0] d;
    for (int i = i0; i <= i1; i++) begin
      d = pix(f, i / H, i % H);
      push(d, (i % H) == H - 1, i == 0);
      send(d, (i % H) == H - 1, i == 0);
    end
  endtask

  // Expected zero fill beats for linear indices i0..i1.
  task automatic pad_beats(input int i0, input int i1);
    for (int i = i0; i <= i1; i++) push('0, (i % H) == H - 1, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata",  m_tdata, 32'd0);
    chk("rst_m_tlast",  32'(m_tlast), 32'd0);
    chk("rst_m_tuser",  32'(m_tuser), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt",  32'(err_cnt), 32'd0);
    chk("rst_locked",   32'(locked), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("hunt_s_tready", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    do_reset();
    chk("tkeep", 32'(m_tkeep), 32'hF);

    // Two clean frames, random back-pressure.
    rdy_mode = 0;
    clean_beats(0, 0, 31);
    clean_beats(1, 0, 31);
    drain();
    chk("clean_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("clean_err_cnt",   32'(err_cnt), 32'd0);
    chk("clean_locked",    32'(locked), 32'd0);

    // Garbage before the first SOF is dropped silently.
    do_reset();
    for (int i = 0; i < 5; i++) send(32'hDEAD_0000 + 32'(i), i == 2, 1'b0);
    chk("garbage_locked",   32'(locked), 32'd0);
    chk("garbage_m_tvalid", 32'(m_tvalid), 32'd0);
    clean_beats(2, 0, 0);
    chk("sof_locked",   32'(locked), 32'd1);
    chk("sof_m_tvalid", 32'(m_tvalid), 32'd1);
    clean_beats(2, 1, 31);
    drain();
    chk("garbage_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("garbage_err_cnt",   32'(err_cnt), 32'd0);

    // Short line: tlast at col 4 of row 1 -> 3 zeros finish row 1, rows 2-3 zero.
    do_reset();
    clean_beats(3, 0, 11);
    push(pix(3, 1, 4), 1'b0, 1'b0);
    pad_beats(13, 31);
    send(pix(3, 1, 4), 1'b1, 1'b0);
    drain();
    chk("short_err_cnt",   32'(err_cnt), 32'd1);
    chk("short_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("short_locked",    32'(locked), 32'd0);

    // Early SOF at col 3 of row 1: 5 + 16 = 21 zeros, then the held SOF opens
    // the next frame.
    clean_beats(4, 0, 10);
    pad_beats(11, 31);
    push(pix(5, 0, 0), 1'b0, 1'b1);
    send(pix(5, 0, 0), 1'b0, 1'b1);
    clean_beats(5, 1, 31);
    drain();
    chk("early_err_cnt",   32'(err_cnt), 32'd2);
    chk("early_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("early_locked",    32'(locked), 32'd0);

    // Long line in the last row: col 7 without tlast still gets tlast, then HUNT.
    do_reset();
    clean_beats(6, 0, 30);
    push(pix(6, 3, 7), 1'b1, 1'b0);
    send(pix(6, 3, 7), 1'b0, 1'b0);
    drain();
    chk("long_locked",    32'(locked), 32'd0);
    chk("long_err_cnt",   32'(err_cnt), 32'd1);
    chk("long_frame_cnt", 32'(frame_cnt), 32'd0);
    send(pix(6, 3, 8), 1'b1, 1'b0);
    clean_beats(7, 0, 31);
    drain();
    chk("long_next_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("long_next_err_cnt",   32'(err_cnt), 32'd1);

    // Reset in the middle of a frame with a stalled beat in the output register.
    rdy_mode = 1;
    clean_beats(8, 0, 3);
    drain();
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(pix(8, 0, 4), 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_pre_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("midrst_pre_locked",   32'(locked), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_m_tvalid",  32'(m_tvalid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_err_cnt",   32'(err_cnt), 32'd0);
    chk("midrst_locked",    32'(locked), 32'd0);
    chk("midrst_s_tready",  32'(s_tready), 32'd0);
    rst      = 1'b0;
    rdy_mode = 0;
    send(pix(9, 0, 9), 1'b0, 1'b0);
    clean_beats(9, 0, 31);
    drain();
    chk("midrst_after_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("midrst_after_err_cnt",   32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
